// File: rtl/water_pkg.sv
// water_pkg: shared states, trend codes and level codes for the water-level path.
package water_pkg;
    typedef enum logic [1:0] {INIT, STABLE, CANDIDATE} wl_state_t;
    localparam logic [1:0] TREND_NONE = 2'b00;
    localparam logic [1:0] TREND_UP   = 2'b01;
    localparam logic [1:0] TREND_DOWN = 2'b10;
    localparam logic [1:0] LVL_0 = 2'b00;
    localparam logic [1:0] LVL_1 = 2'b01;
    localparam logic [1:0] LVL_2 = 2'b10;
    localparam logic [1:0] LVL_3 = 2'b11;
    function automatic logic big_jump(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = (a > b) ? a - b : b - a;
        return d >= 2'd2;
    endfunction
endpackage

// File: rtl/water_level_filter_if.sv
// water_level_filter_if: sensor input and conditioned level outputs.
interface water_level_filter_if #(parameter int NBITS_LEVEL = 2);
    logic [NBITS_LEVEL-1:0] sensor_raw;
    logic                   clear_fault;
    logic [NBITS_LEVEL-1:0] level;
    logic                   level_valid;
    logic                   level_changed;
    logic [1:0]             trend;
    logic                   fault;
    modport master (output sensor_raw, clear_fault, input level, level_valid, level_changed, trend, fault);
    modport slave  (input sensor_raw, clear_fault, output level, level_valid, level_changed, trend, fault);
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for an asynchronous multi-bit input.
module sync2 #(parameter int W = 2) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_q    <= '0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end
    assign o_q = r_q;
endmodule

// File: rtl/water_level_filter.sv
// water_level_filter: synchronise and debounce the raw water-sensor code, then
// report the accepted level with valid, change pulse, trend and sticky fault.
module water_level_filter
    import water_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int NBITS_LEVEL   = 2
) (
    input  logic clk_2,
    input  logic reset_n,
    water_level_filter_if.slave bus
);
    localparam logic [3:0] C_SC    = 4'(STABLE_CYCLES);
    localparam logic [3:0] C_SC_M1 = 4'(STABLE_CYCLES - 1);

    logic [NBITS_LEVEL-1:0] w_sync;
    wl_state_t              r_state, w_state;
    logic [NBITS_LEVEL-1:0] r_cand, w_cand;
    logic [3:0]             r_cnt, w_cnt, w_inc;
    logic [1:0]             r_fill, w_fill;
    logic [NBITS_LEVEL-1:0] r_level, w_level;
    logic                   r_valid, w_valid;
    logic                   r_changed, w_changed;
    logic [1:0]             r_trend, w_trend;
    logic                   r_fault, w_fault;

    sync2 #(.W(NBITS_LEVEL)) u_sync (
        .i_clk   (clk_2),
        .i_rst_n (reset_n),
        .i_d     (bus.sensor_raw),
        .o_q     (w_sync)
    );

    assign w_inc = (w_sync == r_cand) ? r_cnt + 4'd1 : 4'd1;

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= INIT;
            r_cand    <= '0;
            r_cnt     <= '0;
            r_fill    <= '0;
            r_level   <= LVL_0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_trend   <= TREND_NONE;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cand    <= w_cand;
            r_cnt     <= w_cnt;
            r_fill    <= w_fill;
            r_level   <= w_level;
            r_valid   <= w_valid;
            r_changed <= w_changed;
            r_trend   <= w_trend;
            r_fault   <= w_fault;
        end
    end

    // A fault set on the accept edge is assigned after the clear, so it wins.
    always_comb begin
        w_state   = r_state;
        w_cand    = r_cand;
        w_cnt     = r_cnt;
        w_fill    = r_fill;
        w_level   = r_level;
        w_valid   = r_valid;
        w_changed = 1'b0;
        w_trend   = r_trend;
        w_fault   = r_fault & ~bus.clear_fault;
        case (r_state)
            INIT: begin
                if (r_fill != 2'd2) begin
                    w_fill = r_fill + 2'd1;
                end else begin
                    w_cand = w_sync;
                    w_cnt  = w_inc;
                    if (w_inc == C_SC) begin
                        w_level = w_sync;
                        w_valid = 1'b1;
                        w_state = STABLE;
                    end
                end
            end
            STABLE: begin
                if (w_sync != r_level) begin
                    w_cand  = w_sync;
                    w_cnt   = 4'd1;
                    w_state = CANDIDATE;
                end
            end
            CANDIDATE: begin
                if (w_sync == r_level) begin
                    w_cnt   = 4'd0;
                    w_state = STABLE;
                end else if (w_sync != r_cand) begin
                    w_cand = w_sync;
                    w_cnt  = 4'd1;
                end else if (r_cnt == C_SC_M1) begin
                    w_level   = r_cand;
                    w_changed = 1'b1;
                    w_trend   = (r_cand > r_level) ? TREND_UP : TREND_DOWN;
                    w_fault   = big_jump(r_cand, r_level) | w_fault;
                    w_state   = STABLE;
                end else begin
                    w_cnt = r_cnt + 4'd1;
                end
            end
            default: w_state = INIT;
        endcase
    end

    assign bus.level         = r_level;
    assign bus.level_valid   = r_valid;
    assign bus.level_changed = r_changed;
    assign bus.trend         = r_trend;
    assign bus.fault         = r_fault;
endmodule

// File: tb/tb_water_level_filter.sv
// tb_water_level_filter: directed scenarios plus random sensor traffic against
// a run-length reference model of the debounced level.
module tb_water_level_filter;
    localparam int SC = 3;

    logic clk_2 = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;

    water_level_filter_if bus();

    water_level_filter #(.STABLE_CYCLES(SC), .NBITS_LEVEL(2)) dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_2 = ~clk_2;

    logic [1:0] m_hist[$];
    int         m_run;
    logic [1:0] m_last;
    logic [1:0] m_level;
    logic       m_valid;
    logic       m_changed;
    logic [1:0] m_trend;
    logic       m_fault;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_hist.delete();
        m_run = 0;
        m_last = 2'b00;
        m_level = 2'b00;
        m_valid = 1'b0;
        m_changed = 1'b0;
        m_trend = 2'b00;
        m_fault = 1'b0;
    endtask

    // A value is accepted once it has been the synchronised sample for SC
    // consecutive edges; the sample seen at edge n is the raw value of edge n-2.
    task automatic model_edge(input logic [1:0] raw, input logic clr);
        int n;
        int d;
        logic [1:0] obs;
        logic set_f;
        set_f = 1'b0;
        m_changed = 1'b0;
        m_hist.push_back(raw);
        n = m_hist.size();
        if (n >= 3) begin
            obs = m_hist[n-3];
            m_run = (m_run > 0 && obs == m_last) ? m_run + 1 : 1;
            m_last = obs;
            if (!m_valid && m_run == SC) begin
                m_level = obs;
                m_valid = 1'b1;
                m_run = 0;
            end else if (m_valid && obs != m_level && m_run == SC) begin
                d = int'(obs) - int'(m_level);
                if (d < 0) d = -d;
                set_f = (d >= 2);
                m_trend = (obs > m_level) ? 2'b01 : 2'b10;
                m_changed = 1'b1;
                m_level = obs;
                m_run = 0;
            end
        end
        m_fault = set_f ? 1'b1 : (clr ? 1'b0 : m_fault);
    endtask

    task automatic tick(input logic [1:0] raw, input logic clr);
        bus.sensor_raw = raw;
        bus.clear_fault = clr;
        @(posedge clk_2);
        model_edge(raw, clr);
        #1;
        chk("level", 8'(bus.level), 8'(m_level));
        chk("level_valid", 8'(bus.level_valid), 8'(m_valid));
        chk("level_changed", 8'(bus.level_changed), 8'(m_changed));
        chk("trend", 8'(bus.trend), 8'(m_trend));
        chk("fault", 8'(bus.fault), 8'(m_fault));
    endtask

    task automatic do_reset(input logic [1:0] raw);
        #2;
        reset_n = 1'b0;
        bus.sensor_raw = raw;
        bus.clear_fault = 1'b0;
        #1;
        model_clear();
        chk("rst_level", 8'(bus.level), 8'h0);
        chk("rst_valid", 8'(bus.level_valid), 8'h0);
        chk("rst_changed", 8'(bus.level_changed), 8'h0);
        chk("rst_trend", 8'(bus.trend), 8'h0);
        chk("rst_fault", 8'(bus.fault), 8'h0);
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.sensor_raw = 2'b00;
        bus.clear_fault = 1'b0;
        model_clear();
        @(posedge clk_2);
        #1;

        // Acquisition: valid rises on edge 5 after release.
        do_reset(2'b10);
        for (int i = 0; i < 4; i++) tick(2'b10, 1'b0);
        chk("acq_valid_e4", 8'(bus.level_valid), 8'h0);
        tick(2'b10, 1'b0);
        chk("acq_level_e5", 8'(bus.level), 8'h2);
        chk("acq_valid_e5", 8'(bus.level_valid), 8'h1);
        chk("acq_changed_e5", 8'(bus.level_changed), 8'h0);
        chk("acq_trend_e5", 8'(bus.trend), 8'h0);

        // Single step 00 -> 01, accepted on E0+4.
        do_reset(2'b00);
        for (int i = 0; i < 6; i++) tick(2'b00, 1'b0);
        for (int i = 0; i < 4; i++) tick(2'b01, 1'b0);
        chk("step_level_e3", 8'(bus.level), 8'h0);
        tick(2'b01, 1'b0);
        chk("step_level_e4", 8'(bus.level), 8'h1);
        chk("step_pulse_e4", 8'(bus.level_changed), 8'h1);
        chk("step_trend_e4", 8'(bus.trend), 8'h1);
        chk("step_fault_e4", 8'(bus.fault), 8'h0);
        tick(2'b01, 1'b0);
        chk("step_pulse_e5", 8'(bus.level_changed), 8'h0);

        // Glitch: two cycles of 00 are rejected.
        tick(2'b00, 1'b0);
        tick(2'b00, 1'b0);
        for (int i = 0; i < 6; i++) tick(2'b01, 1'b0);
        chk("glitch_level", 8'(bus.level), 8'h1);
        chk("glitch_trend", 8'(bus.trend), 8'h1);

        // Candidate switch: 01 for two cycles, then 10 held from level 00.
        for (int i = 0; i < 6; i++) tick(2'b00, 1'b0);
        tick(2'b01, 1'b0);
        tick(2'b01, 1'b0);
        for (int i = 0; i < 4; i++) tick(2'b10, 1'b0);
        chk("switch_level_early", 8'(bus.level), 8'h0);
        tick(2'b10, 1'b0);
        chk("switch_level", 8'(bus.level), 8'h2);
        chk("switch_trend", 8'(bus.trend), 8'h1);
        chk("switch_fault", 8'(bus.fault), 8'h1);

        // Fault clear: reach 11 with fault cleared, then jump to 00.
        for (int i = 0; i < 6; i++) tick(2'b11, 1'b1);
        chk("fc_pre_fault", 8'(bus.fault), 8'h0);
        chk("fc_pre_level", 8'(bus.level), 8'h3);
        for (int i = 0; i < 5; i++) tick(2'b00, 1'b0);
        chk("fc_set_fault", 8'(bus.fault), 8'h1);
        chk("fc_set_trend", 8'(bus.trend), 8'h2);
        tick(2'b00, 1'b1);
        chk("fc_cleared", 8'(bus.fault), 8'h0);
        for (int i = 0; i < 5; i++) tick(2'b11, 1'b1);
        chk("fc_set_wins", 8'(bus.fault), 8'h1);
        chk("fc_set_wins_lvl", 8'(bus.level), 8'h3);

        // Reset in CANDIDATE, then re-acquire in five edges.
        tick(2'b01, 1'b0);
        tick(2'b01, 1'b0);
        tick(2'b01, 1'b0);
        chk("midrst_pre_valid", 8'(bus.level_valid), 8'h1);
        do_reset(2'b01);
        for (int i = 0; i < 4; i++) tick(2'b01, 1'b0);
        chk("reacq_valid_e4", 8'(bus.level_valid), 8'h0);
        tick(2'b01, 1'b0);
        chk("reacq_valid_e5", 8'(bus.level_valid), 8'h1);
        chk("reacq_level_e5", 8'(bus.level), 8'h1);

        // Random traffic with variable hold lengths and sporadic clears.
        do_reset(2'(($urandom_range(0, 3))));
        for (int i = 0; i < 150; i++) begin
            logic [1:0] raw;
            int len;
            raw = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) tick(raw, $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
